// File: rtl/rr_grant_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant, a bounded hold time
// and a forced idle cycle between grants.
module rr_grant_arbiter8 #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic       gnt_en,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt,
    output logic       timeout
);

    // Handshake: req[i] stays high while requester i wants the resource. A grant
    // ends when the holder raises done, drops its req, or holds for HOLD_MAX cycles.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [3:0] hold_cnt, hold_cnt_nxt;
    logic       gnt_en_nxt;
    logic [2:0] gnt_idx_nxt;
    logic [7:0] gnt_nxt;
    logic       timeout_nxt;

    logic       pick_found;
    logic [2:0] pick_idx;
    logic [2:0] cand;

    logic       expire;
    logic       drop;
    logic       release_now;

    // Rotating priority search: ptr first, then ptr+1, ... wrapping modulo 8.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        cand       = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign expire      = (hold_cnt == HOLD_LAST);
    assign drop        = !req[gnt_idx];
    assign release_now = done || drop || expire;

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        gnt_en_nxt   = 1'b0;
        gnt_idx_nxt  = 3'd0;
        gnt_nxt      = 8'h00;
        timeout_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt    = GRANT;
                    gnt_en_nxt   = 1'b1;
                    gnt_idx_nxt  = pick_idx;
                    gnt_nxt      = 8'h01 << pick_idx;
                    hold_cnt_nxt = 4'd0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    // Always pass through IDLE so a new grant never abuts the old one.
                    state_nxt    = IDLE;
                    ptr_nxt      = gnt_idx + 3'd1;
                    hold_cnt_nxt = 4'd0;
                    timeout_nxt  = expire && !done && !drop;
                end else begin
                    gnt_en_nxt   = 1'b1;
                    gnt_idx_nxt  = gnt_idx;
                    gnt_nxt      = gnt;
                    hold_cnt_nxt = expire ? hold_cnt : hold_cnt + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            hold_cnt <= 4'd0;
            gnt_en   <= 1'b0;
            gnt_idx  <= 3'd0;
            gnt      <= 8'h00;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
            gnt_en   <= gnt_en_nxt;
            gnt_idx  <= gnt_idx_nxt;
            gnt      <= gnt_nxt;
            timeout  <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Directed bench for rr_grant_arbiter8: three instances (HOLD_MAX 15, 4, 1) share
// stimulus; a queue-based scoreboard checks the selected instance every cycle.
module tb_rr_grant_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;

    logic       en_a, en_b, en_c;
    logic [2:0] idx_a, idx_b, idx_c;
    logic [7:0] gnt_a, gnt_b, gnt_c;
    logic       to_a, to_b, to_c;

    logic [12:0] act [3];
    assign act[0] = {en_a, idx_a, gnt_a, to_a};
    assign act[1] = {en_b, idx_b, gnt_b, to_b};
    assign act[2] = {en_c, idx_c, gnt_c, to_c};

    logic [12:0] exp_q[$];
    int          dut_q[$];
    string       name_q[$];

    int          sel;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [12:0] mon_e;
    logic [12:0] mon_a;
    int          mon_w;
    string       mon_n;

    // Clock / reset
    always #5 clk = ~clk;

    rr_grant_arbiter8 #(.HOLD_MAX(15)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt_en(en_a), .gnt_idx(idx_a), .gnt(gnt_a), .timeout(to_a)
    );
    rr_grant_arbiter8 #(.HOLD_MAX(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt_en(en_b), .gnt_idx(idx_b), .gnt(gnt_b), .timeout(to_b)
    );
    rr_grant_arbiter8 #(.HOLD_MAX(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt_en(en_c), .gnt_idx(idx_c), .gnt(gnt_c), .timeout(to_c)
    );

    // Expected output words {gnt_en, gnt_idx, gnt, timeout}
    function automatic logic [12:0] g(input logic [2:0] i);
        logic [7:0] oh;
        oh = 8'h01 << i;
        return {1'b1, i, oh, 1'b0};
    endfunction

    function automatic logic [12:0] z(input logic to);
        return {1'b0, 3'd0, 8'h00, to};
    endfunction

    // Driver: apply inputs, queue the output expected after the next edge.
    task automatic step(input logic [7:0] r, input logic d, input logic rn,
                        input logic [12:0] e, input string nm);
        req   = r;
        done  = d;
        rst_n = rn;
        exp_q.push_back(e);
        dut_q.push_back(sel);
        name_q.push_back(nm);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step(8'hFF, 1'b1, 1'b0, z(1'b0), "reset0");
        step(8'hA5, 1'b0, 1'b0, z(1'b0), "reset1");
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_w = dut_q.pop_front();
            mon_n = name_q.pop_front();
            mon_a = act[mon_w];
            n_tests++;
            if (mon_a !== mon_e) begin
                n_fail++;
                $display("FAIL %s (dut %0d): got en=%0b idx=%0d gnt=%02h to=%0b, expected en=%0b idx=%0d gnt=%02h to=%0b",
                         mon_n, mon_w, mon_a[12], mon_a[11:9], mon_a[8:1], mon_a[0],
                         mon_e[12], mon_e[11:9], mon_e[8:1], mon_e[0]);
            end
        end
    end

    initial begin
        req   = 8'h00;
        done  = 1'b0;
        rst_n = 1'b0;
        sel   = 0;

        // Full round with all requesting, done on each grant's second cycle.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, 1'b0, 1'b1, g(3'(k % 8)), $sformatf("rr_arb%0d", k));
            step(8'hFF, 1'b0, 1'b1, g(3'(k % 8)), $sformatf("rr_hold%0d", k));
            step(8'hFF, 1'b1, 1'b1, z(1'b0), $sformatf("rr_rel%0d", k));
        end
        step(8'h00, 1'b0, 1'b1, z(1'b0), "idle_noreq0");
        step(8'h00, 1'b0, 1'b1, z(1'b0), "idle_noreq1");

        // Pointer wrap 7 -> 0 after first moving ptr away from 0.
        do_reset();
        step(8'h02, 1'b0, 1'b1, g(3'd1), "wrap_g1");
        step(8'h02, 1'b1, 1'b1, z(1'b0), "wrap_r1");
        step(8'h80, 1'b0, 1'b1, g(3'd7), "wrap_g7");
        step(8'h80, 1'b1, 1'b1, z(1'b0), "wrap_r7");
        step(8'h81, 1'b0, 1'b1, g(3'd0), "wrap_g0");
        step(8'h81, 1'b1, 1'b1, z(1'b0), "wrap_r0");

        // Reset in the middle of a grant; arbitration restarts from ptr 0.
        do_reset();
        step(8'h01, 1'b0, 1'b1, g(3'd0), "rst_g0");
        step(8'h01, 1'b1, 1'b1, z(1'b0), "rst_r0");
        step(8'h20, 1'b0, 1'b1, g(3'd5), "rst_g5");
        step(8'h20, 1'b0, 1'b0, z(1'b0), "rst_mid");
        step(8'h21, 1'b0, 1'b1, g(3'd0), "rst_first");
        step(8'h21, 1'b1, 1'b1, z(1'b0), "rst_rel");

        // Holder drops its request; other requests must not disturb the grant.
        do_reset();
        step(8'h04, 1'b0, 1'b1, g(3'd2), "drop_g2");
        step(8'hF4, 1'b0, 1'b1, g(3'd2), "drop_others");
        step(8'h40, 1'b0, 1'b1, z(1'b0), "drop_rel");
        step(8'h40, 1'b0, 1'b1, g(3'd6), "drop_g6");
        step(8'h40, 1'b1, 1'b1, z(1'b0), "drop_done");

        // Full HOLD_MAX=15 expiry.
        do_reset();
        step(8'h01, 1'b0, 1'b1, g(3'd0), "h15_arb");
        for (int k = 0; k < 14; k++)
            step(8'h01, 1'b0, 1'b1, g(3'd0), $sformatf("h15_hold%0d", k));
        step(8'h01, 1'b0, 1'b1, z(1'b1), "h15_timeout");
        step(8'h00, 1'b0, 1'b1, z(1'b0), "h15_pulse_end");

        // HOLD_MAX=4: expiry with timeout, regrant after one gap.
        sel = 1;
        do_reset();
        step(8'h08, 1'b0, 1'b1, g(3'd3), "h4_arb");
        for (int k = 0; k < 3; k++)
            step(8'h08, 1'b0, 1'b1, g(3'd3), $sformatf("h4_hold%0d", k));
        step(8'h08, 1'b0, 1'b1, z(1'b1), "h4_timeout");
        step(8'h08, 1'b0, 1'b1, g(3'd3), "h4_regrant");
        step(8'h08, 1'b1, 1'b1, z(1'b0), "h4_done");

        // HOLD_MAX=4: done coincides with expiry, so no timeout.
        do_reset();
        step(8'h08, 1'b0, 1'b1, g(3'd3), "h4b_arb");
        for (int k = 0; k < 3; k++)
            step(8'h08, 1'b0, 1'b1, g(3'd3), $sformatf("h4b_hold%0d", k));
        step(8'h08, 1'b1, 1'b1, z(1'b0), "h4b_done_exp");
        step(8'h00, 1'b0, 1'b1, z(1'b0), "h4b_idle");

        // HOLD_MAX=1: single-cycle grants.
        sel = 2;
        do_reset();
        step(8'h08, 1'b0, 1'b1, g(3'd3), "h1_arb");
        step(8'h08, 1'b0, 1'b1, z(1'b1), "h1_timeout");
        step(8'h08, 1'b0, 1'b1, g(3'd3), "h1_regrant");
        step(8'h08, 1'b1, 1'b1, z(1'b0), "h1_done");
        step(8'h18, 1'b0, 1'b1, g(3'd4), "h1_next");
        step(8'h00, 1'b0, 1'b1, z(1'b0), "h1_drop");

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter8.md
RR_GRANT_ARBITER8 -- requirements
Module: rr_grant_arbiter8

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 15, maximum consecutive cycles one grant may be held (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req  input  8  request per requester; bit i = requester i.
REQ-005 SHALL have port done  input  1  current grant holder releases the resource this cycle.
REQ-006 SHALL have port gnt_en  output  1  a grant is active (enable to downstream 3-to-8 decode).
REQ-007 SHALL have port gnt_idx  output  3  binary index of granted requester.
REQ-008 SHALL have port gnt  output  8  one-hot grant; equals decode of {gnt_en,gnt_idx}, all-zero when gnt_en=0.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse: grant revoked by HOLD_MAX expiry.

Function
REQ-010 SHALL implement a two-state FSM: IDLE, GRANT; all outputs registered.
REQ-011 SHALL keep a 3-bit round-robin pointer ptr = highest-priority index for next arbitration.
REQ-012 IDLE, req!=0: select first i with req[i]=1 searching ptr, ptr+1, ... mod 8; next cycle gnt_en=1, gnt_idx=i, state GRANT, hold_cnt=0.
REQ-013 IDLE, req=0: remain IDLE, outputs zero, ptr unchanged.
REQ-014 Grant latency: req sampled at edge N, gnt visible after edge N (one cycle).
REQ-015 GRANT: hold_cnt increments by one each cycle held; saturates at HOLD_MAX-1, never wraps.
REQ-016 GRANT release when any of: done=1; req[gnt_idx]=0; hold_cnt==HOLD_MAX-1.
REQ-017 On release: next cycle gnt_en=0, gnt=0, gnt_idx=0, state IDLE, ptr=gnt_idx+1 mod 8 (7 wraps to 0).
REQ-018 Break-before-make: at least one cycle with gnt_en=0 between any two grants, even same requester.
REQ-019 timeout=1 for exactly the cycle after release only if release cause was hold expiry alone; done=1 or req drop in same cycle suppresses timeout.
REQ-020 Requests other than gnt_idx SHALL NOT affect an active grant.
REQ-021 HOLD_MAX=1: every grant lasts exactly one cycle, then timeout pulse unless done/req drop concurrent.
REQ-022 gnt SHALL have at most one bit set in every cycle.
REQ-023 Starvation bound: a continuously asserted request is granted within 7*(HOLD_MAX+1)+1 cycles.

Reset
REQ-024 rst_n=0 at an edge: state IDLE, ptr=0, hold_cnt=0, gnt_en=0, gnt_idx=0, gnt=8'h00, timeout=0, regardless of state or inputs.
REQ-025 Reset mid-grant drops grant the following cycle, no timeout pulse; first arbitration after reset starts from ptr=0.
REQ-026 While rst_n=0, req and done SHALL be ignored.

Verification
REQ-027 Reset, req=8'hFF held, done pulsed each grant's 2nd cycle -> grants in order idx 0,1,...,7,0; each 2 cycles, one-cycle gap between; gnt one-hot (8'h01, 8'h02, ...).
REQ-028 HOLD_MAX=4, req=8'h08 held, done=0 -> gnt=8'h08 for 4 cycles, gnt=0 with timeout=1 next cycle, regrant idx 3 after one gap.
REQ-029 Grant on idx 7, release via done, then req=8'h81 -> next grant idx 0 (ptr wrap 7->0).
REQ-030 HOLD_MAX=4, done=1 asserted in the cycle hold expires -> release, timeout stays 0.
REQ-031 Grant on idx 5, rst_n=0 for one cycle -> gnt=0, timeout=0; req=8'h20|8'h01 after reset -> idx 0 granted first.
REQ-032 Granted idx 2, req[2] drops while req=8'h40 -> gnt=0 next cycle, then gnt=8'h40, ptr=3 before arbitration.
